// File: rtl/adc_frame_deserializer.sv
// Multi-lane serial-to-parallel deserializer for LVDS ADC lanes with a shared frame lane
// and bit-slip word alignment (automatic training FSM or manual slip).
module adc_frame_deserializer #(
    parameter int              WIDTH         = 8,
    parameter int              CHANNELS      = 2,
    parameter logic [WIDTH-1:0] FRAME_PATTERN = 8'hF0,
    parameter int              LOCK_COUNT    = 4,
    parameter int              SLIP_WAIT     = 2
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        bit_en,
    input  logic [CHANNELS-1:0]         D,
    input  logic                        FR,
    input  logic                        auto_align,
    input  logic                        bit_slip,
    output logic [CHANNELS*WIDTH-1:0]   Q,
    output logic                        q_valid,
    output logic                        locked,
    output logic [$clog2(WIDTH)-1:0]    slip_count,
    output logic                        align_err
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {ST_SEARCH, ST_WAIT, ST_LOCKED} state_t;

    // Only WIDTH-1 history bits are kept; the live input bit completes the word.
    logic [CHANNELS-1:0][WIDTH-2:0] sr;
    logic [CHANNELS-1:0][WIDTH-1:0] q_r;
    logic [WIDTH-2:0]               fr_sr;
    logic [WIDTH-1:0]               frame_q;
    logic [CW-1:0]                  cnt;
    logic                           slip_pend;
    logic                           bit_slip_q;
    logic                           boundary;
    logic                           slip_req;
    logic                           fsm_slip;
    logic                           frame_match;

    state_t     state_q, state_d;
    logic [7:0] match_q, match_d;
    logic [7:0] tries_q, tries_d;
    logic [7:0] wait_q, wait_d;
    logic       miss_q, miss_d;
    logic       err_d;

    assign boundary    = bit_en && !slip_pend && (cnt == CW'(WIDTH-1));
    assign slip_req    = auto_align ? fsm_slip : (bit_slip && !bit_slip_q);
    assign frame_match = (frame_q == FRAME_PATTERN);
    assign Q           = q_r;
    assign locked      = (state_q == ST_LOCKED);

    always_ff @(posedge clk) begin
        if (rst) begin
            sr         <= '0;
            q_r        <= '0;
            fr_sr      <= '0;
            frame_q    <= '0;
            cnt        <= '0;
            slip_pend  <= 1'b0;
            slip_count <= '0;
            bit_slip_q <= 1'b0;
            q_valid    <= 1'b0;
        end else begin
            bit_slip_q <= bit_slip;
            q_valid    <= boundary;
            if (bit_en) begin
                fr_sr <= {fr_sr[WIDTH-3:0], FR};
                for (int k = 0; k < CHANNELS; k++)
                    sr[k] <= {sr[k][WIDTH-3:0], D[k]};
                // A pending slip swallows this bit: the counter holds, pushing boundaries out by one.
                if (slip_pend) begin
                    slip_pend  <= 1'b0;
                    slip_count <= (slip_count == CW'(WIDTH-1)) ? '0 : slip_count + 1'b1;
                end else begin
                    cnt <= (cnt == CW'(WIDTH-1)) ? '0 : cnt + 1'b1;
                end
            end
            if (boundary) begin
                frame_q <= {fr_sr, FR};
                for (int k = 0; k < CHANNELS; k++)
                    q_r[k] <= {sr[k], D[k]};
            end
            if (slip_req && !slip_pend)
                slip_pend <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_SEARCH;
            match_q   <= '0;
            tries_q   <= '0;
            wait_q    <= '0;
            miss_q    <= 1'b0;
            align_err <= 1'b0;
        end else begin
            state_q   <= state_d;
            match_q   <= match_d;
            tries_q   <= tries_d;
            wait_q    <= wait_d;
            miss_q    <= miss_d;
            align_err <= err_d;
        end
    end

    // The FSM sees each captured frame word once, in the cycle q_valid is high.
    always_comb begin
        state_d  = state_q;
        match_d  = match_q;
        tries_d  = tries_q;
        wait_d   = wait_q;
        miss_d   = miss_q;
        err_d    = align_err;
        fsm_slip = 1'b0;
        if (!auto_align) begin
            state_d = ST_SEARCH;
            match_d = '0;
            tries_d = '0;
            wait_d  = '0;
            miss_d  = 1'b0;
        end else if (q_valid) begin
            case (state_q)
                ST_SEARCH: begin
                    if (frame_match) begin
                        if (match_q == 8'(LOCK_COUNT-1)) begin
                            state_d = ST_LOCKED;
                            match_d = '0;
                            tries_d = '0;
                            miss_d  = 1'b0;
                        end else begin
                            match_d = match_q + 8'd1;
                        end
                    end else begin
                        fsm_slip = 1'b1;
                        match_d  = '0;
                        wait_d   = '0;
                        state_d  = (SLIP_WAIT == 0) ? ST_SEARCH : ST_WAIT;
                        if (tries_q == 8'(WIDTH-1)) begin
                            err_d   = 1'b1;
                            tries_d = '0;
                        end else begin
                            tries_d = tries_q + 8'd1;
                        end
                    end
                end
                ST_WAIT: begin
                    if (wait_q == 8'(SLIP_WAIT-1)) begin
                        state_d = ST_SEARCH;
                        wait_d  = '0;
                    end else begin
                        wait_d = wait_q + 8'd1;
                    end
                end
                ST_LOCKED: begin
                    if (frame_match) begin
                        miss_d = 1'b0;
                    end else if (miss_q) begin
                        state_d = ST_SEARCH;
                        miss_d  = 1'b0;
                        match_d = '0;
                    end else begin
                        miss_d = 1'b1;
                    end
                end
                default: state_d = ST_SEARCH;
            endcase
        end
    end

endmodule

// File: tb/tb_adc_frame_deserializer.sv
// Bench for adc_frame_deserializer: scenario table for alignment, hand sequences for
// lock/slip corner cases, and a randomized manual-slip run against a bit-index model.
module tb_adc_frame_deserializer;

    localparam int W  = 8;
    localparam int CH = 2;

    logic          clk = 1'b0;
    logic          rst, bit_en, FR, auto_align, bit_slip;
    logic [CH-1:0] D;
    logic [CH*W-1:0] Q;
    logic          q_valid, locked, align_err;
    logic [2:0]    slip_count;

    adc_frame_deserializer #(.WIDTH(W), .CHANNELS(CH), .FRAME_PATTERN(8'hF0),
                             .LOCK_COUNT(4), .SLIP_WAIT(2)) dut (
        .clk(clk), .rst(rst), .bit_en(bit_en), .D(D), .FR(FR),
        .auto_align(auto_align), .bit_slip(bit_slip), .Q(Q), .q_valid(q_valid),
        .locked(locked), .slip_count(slip_count), .align_err(align_err));

    always #5 clk = ~clk;

    int checks = 0, passed = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // stream generator state
    logic [7:0] d0_pat, d1_pat, fr_pat;
    int prefix, period, pos, cyc, corrupt_lo, corrupt_hi;
    int qv_count, last_gap, last_qv, lock_word;
    bit unlock_seen;

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        if (q_valid) begin
            qv_count++;
            last_gap = cyc - last_qv;
            last_qv  = cyc;
        end
        if (!locked) unlock_seen = 1'b1;
        else if (lock_word < 0) lock_word = qv_count;
    endtask

    function automatic logic pbit(input logic [7:0] pat, input int p);
        if (p < prefix) return 1'b1;
        return pat[W-1-((p-prefix)%W)];
    endfunction

    function automatic logic frbit(input int p);
        int w;
        logic b;
        b = pbit(fr_pat, p);
        if (p < prefix) return b;
        w = (p - prefix) / W;
        return (w >= corrupt_lo && w <= corrupt_hi) ? ~b : b;
    endfunction

    task automatic run_words(input int n);
        int target;
        target = pos + n*W;
        while (pos < target) begin
            bit_en = (cyc % period == 0);
            if (bit_en) begin
                D   = {pbit(d1_pat, pos), pbit(d0_pat, pos)};
                FR  = frbit(pos);
                pos++;
            end else begin
                D  = 2'($urandom());
                FR = 1'($urandom());
            end
            tick();
        end
        bit_en = 1'b0;
        tick();
        tick();
    endtask

    task automatic do_reset();
        rst = 1'b1; bit_en = 1'b1; bit_slip = 1'b0;
        repeat (2) begin
            D = 2'($urandom()); FR = 1'($urandom());
            tick();
        end
        rst = 1'b0; bit_en = 1'b0;
        pos = 0; cyc = 0; qv_count = 0; last_gap = 0; last_qv = 0; lock_word = -1;
        corrupt_lo = -1; corrupt_hi = -1;
    endtask

    task automatic setup(input logic [7:0] d0, input logic [7:0] d1, input logic [7:0] fr,
                         input int pf, input int per, input logic aa);
        d0_pat = d0; d1_pat = d1; fr_pat = fr; prefix = pf; period = per; auto_align = aa;
    endtask

    typedef struct {
        logic [7:0] d0, d1;
        int         prefix, period;
        logic [7:0] exp_q0, exp_q1;
        int         exp_slip;
    } vec_t;

    vec_t vecs[5];

    // randomized-run model state
    logic [CH-1:0] hist[$];
    logic [CH*W-1:0] exp_q;
    int nb, nextb, scnt;
    bit pend, pend0, expv, rise, prev_bs;

    initial begin
        vecs[0] = '{8'hB7, 8'h5A, 0, 1, 8'hB7, 8'h5A, 0};
        vecs[1] = '{8'hB7, 8'h5A, 3, 1, 8'hB7, 8'h5A, 3};
        vecs[2] = '{8'hB7, 8'h5A, 3, 3, 8'hB7, 8'h5A, 3};
        vecs[3] = '{8'h3C, 8'h81, 5, 1, 8'h3C, 8'h81, 5};
        vecs[4] = '{8'hC3, 8'h0F, 7, 2, 8'hC3, 8'h0F, 7};

        rst = 1'b1; bit_en = 1'b0; D = '0; FR = 1'b0; auto_align = 1'b1; bit_slip = 1'b0;
        cyc = 0; period = 1;

        // automatic alignment from several offsets and bit_en rates
        for (int i = 0; i < 5; i++) begin
            setup(vecs[i].d0, vecs[i].d1, 8'hF0, vecs[i].prefix, vecs[i].period, 1'b1);
            do_reset();
            run_words(40);
            chk($sformatf("vec%0d_q0", i), Q[7:0], vecs[i].exp_q0);
            chk($sformatf("vec%0d_q1", i), Q[15:8], vecs[i].exp_q1);
            chk($sformatf("vec%0d_slip", i), slip_count, vecs[i].exp_slip);
            chk($sformatf("vec%0d_locked", i), locked, 1);
        end

        // aligned stream: word cadence and lock exactly after the 4th frame word
        setup(8'hB7, 8'h5A, 8'hF0, 0, 1, 1'b1);
        do_reset();
        run_words(10);
        chk("aligned_gap", last_gap, 8);
        chk("aligned_lock_word", lock_word, 4);
        chk("aligned_err", align_err, 0);

        // manual slip: level held for a whole word yields one slip
        setup(8'hB7, 8'h5A, 8'hF0, 0, 1, 1'b0);
        do_reset();
        run_words(10);
        chk("manual_pre_q0", Q[7:0], 8'hB7);
        bit_slip = 1'b1;
        run_words(1);
        bit_slip = 1'b0;
        run_words(10);
        chk("manual_slip", slip_count, 1);
        chk("manual_q0", Q[7:0], 8'h6F);
        chk("manual_q1", Q[15:8], 8'hB4);
        chk("manual_locked", locked, 0);

        // switch to auto with slip_count retained: 7 more slips wrap back to 0
        auto_align = 1'b1;
        run_words(40);
        chk("switch_locked", locked, 1);
        chk("switch_slip", slip_count, 0);
        chk("switch_q0", Q[7:0], 8'hB7);
        chk("switch_err", align_err, 0);

        // lock loss: one bad frame word tolerated, two consecutive drop lock
        setup(8'hB7, 8'h5A, 8'hF0, 0, 1, 1'b1);
        do_reset();
        run_words(8);
        chk("loss_locked0", locked, 1);
        corrupt_lo = 9; corrupt_hi = 9;
        unlock_seen = 1'b0;
        run_words(5);
        chk("loss_single_held", unlock_seen, 0);
        corrupt_lo = 14; corrupt_hi = 15;
        unlock_seen = 1'b0;
        run_words(5);
        chk("loss_double_dropped", unlock_seen, 1);
        run_words(10);
        chk("loss_relocked", locked, 1);
        chk("loss_slip", slip_count, 0);

        // no frame: full sweep fails -> sticky align_err
        setup(8'hB7, 8'h5A, 8'h00, 0, 1, 1'b1);
        do_reset();
        run_words(18);
        chk("noframe_err_early", align_err, 0);
        run_words(12);
        chk("noframe_err", align_err, 1);
        chk("noframe_locked", locked, 0);
        run_words(4);
        chk("noframe_err_sticky", align_err, 1);

        // reset with random inputs clears everything, including align_err
        do_reset();
        chk("rst_q", Q, 0);
        chk("rst_qv", q_valid, 0);
        chk("rst_locked", locked, 0);
        chk("rst_slip", slip_count, 0);
        chk("rst_err", align_err, 0);

        // randomized manual-mode run against a bit-index model
        auto_align = 1'b0;
        do_reset();
        hist.delete();
        nb = 0; nextb = W; scnt = 0; pend = 0; prev_bs = 0; exp_q = '0;
        for (int c = 0; c < 3000; c++) begin
            bit_en   = 1'($urandom_range(0, 1));
            D        = 2'($urandom());
            FR       = 1'($urandom());
            bit_slip = ($urandom_range(0, 3) == 0);
            pend0 = pend;
            rise  = bit_slip && !prev_bs;
            prev_bs = bit_slip;
            expv  = 0;
            if (bit_en) begin
                hist.push_back(D);
                nb++;
                if (pend0) begin
                    nextb++;
                    scnt = (scnt + 1) % W;
                    pend = 0;
                end else if (nb == nextb) begin
                    for (int k = 0; k < CH; k++)
                        for (int j = 0; j < W; j++)
                            exp_q[k*W + W-1-j] = hist[hist.size()-W+j][k];
                    expv  = 1;
                    nextb = nextb + W;
                end
            end
            if (rise && !pend0) pend = 1;
            tick();
            chk("rand_qv", q_valid, expv);
            chk("rand_q", Q, exp_q);
            chk("rand_slip", slip_count, scnt);
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/adc_frame_deserializer.md
Name: adc_frame_deserializer

Overview:
- Multi-channel serial-to-parallel converter for LVDS ADC lanes, sampled in the fabric clock domain.
- Parametrised word width and channel count; one shared frame (FR) lane.
- Automatic word alignment: a bit-slip training FSM searches for the frame pattern, then holds lock. Manual bit-slip mode is kept for bring-up.
- Sits between the input bit samplers and the servo DSP input registers.

Parameters:
- WIDTH, 8, bits per word per lane (4..16).
- CHANNELS, 2, number of data lanes.
- FRAME_PATTERN, 8'hF0, expected frame word; WIDTH bits wide.
- LOCK_COUNT, 4, consecutive matching frame words required to declare lock.
- SLIP_WAIT, 2, captured words discarded after each automatic slip.

Ports:
- clk  in  1  fabric clock; all logic on rising edge.
- rst  in  1  synchronous reset, active-high.
- bit_en  in  1  qualifies one new serial bit on every lane this cycle.
- D  in  CHANNELS  serial data bit per lane.
- FR  in  1  serial frame bit.
- auto_align  in  1  1 = FSM controls slips; 0 = manual bit_slip.
- bit_slip  in  1  manual slip request; rising edge acted on only when auto_align=0.
- Q  out  CHANNELS*WIDTH  lane k word at [k*WIDTH +: WIDTH]; first-received bit is the MSB.
- q_valid  out  1  one-cycle strobe when Q updates.
- locked  out  1  frame alignment achieved.
- slip_count  out  $clog2(WIDTH)  current slip offset mod WIDTH.
- align_err  out  1  sticky; a full sweep of WIDTH slips failed to lock.

Behaviour:
- Reset: Q=0, q_valid=0, locked=0, slip_count=0, align_err=0; FSM=SEARCH; all counters and shift registers 0. rst takes priority over every other event.
- Shifting: on bit_en, each lane shift register does sr <= {sr[WIDTH-2:0], D[k]}. FR is shifted the same way. No change when bit_en=0.
- Bit counter: cnt 0..WIDTH-1, advances on bit_en.
- Word boundary = bit_en && cnt==WIDTH-1 && no slip pending.
  - At the boundary, Q and the frame word capture {sr[WIDTH-2:0], bit}.
  - q_valid=1 on the following cycle for exactly one cycle.
  - Latency: one clk after the bit_en cycle carrying the LSB.
- Slip: holds cnt for one bit_en, delaying all subsequent boundaries by one bit; slip_count increments mod WIDTH.
  - At most one slip pending at a time; further requests while pending are ignored.
  - A slip requested in the same cycle as a boundary applies from the next bit.
- Q and q_valid run regardless of lock; consumers gate data with locked.
- FSM, active when auto_align=1; evaluated on each captured frame word:
  - SEARCH:
    - Match: match_cnt++. When match_cnt==LOCK_COUNT, go to LOCKED, locked=1, tries=0.
    - Mismatch: request slip, match_cnt=0, tries++, go to WAIT.
    - When tries reaches WIDTH: align_err=1 (sticky until rst), tries=0, keep searching.
  - WAIT: discard SLIP_WAIT captured words, then go to SEARCH.
  - LOCKED:
    - A single mismatch is tolerated.
    - Two consecutive mismatches: locked=0, match_cnt=0, go to SEARCH.
    - A match clears the mismatch count.
- auto_align=0:
  - FSM forced to SEARCH with counters cleared; locked=0.
  - Each bit_slip rising edge requests one slip.
  - bit_slip is edge-detected internally, so a level held high gives one slip.
- auto_align changed mid-operation: takes effect next cycle. slip_count and already-captured Q are retained.

Test Plan (WIDTH=8, CHANNELS=2, FRAME_PATTERN=8'hF0, bit_en=1 unless stated):
- Reset: drive random D/FR, assert rst 2 cycles -> Q=0, q_valid=0, locked=0, slip_count=0, align_err=0 on the cycle after reset.
- Aligned stream: FR=11110000 repeating, D[0]=10110111 repeating (0xB7), D[1]=0x5A -> q_valid every 8 cycles; Q[7:0]=0xB7, Q[15:8]=0x5A; locked=1 after the 4th frame word; slip_count=0.
- Misaligned by 3 bits (stream prefixed with 3 extra bits) -> FSM slips; locked=1 with slip_count=3 and Q[7:0]=0xB7. Repeat with bit_en asserted every 3rd cycle -> same final values.
- Manual: auto_align=0 on the aligned stream, single bit_slip pulse -> slip_count=1, Q[7:0]=0x6F from the following words; locked=0.
- Lock loss: while locked, corrupt one frame word -> locked stays 1; corrupt two consecutive frame words -> locked=0, then re-locks within the sweep.
- No frame: FR held 0 -> after 8 slips align_err=1 and locked=0; assert rst -> align_err=0.
